// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit with lane alignment, block-RAM latency and a memory-mapped I/O channel
module mem_stage_lsu #(
    parameter int         ADDR_W    = 12,
    parameter int         MEM_LAT   = 1,
    parameter logic [3:0] IO_REGION = 4'h8,
    parameter int         IO_TMO    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              err,
    output logic              stall,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic              io_valid,
    input  logic              io_ready,
    output logic              io_we,
    output logic [7:0]        io_addr,
    output logic [31:0]       io_wdata,
    input  logic              io_rvalid,
    input  logic [31:0]       io_rdata
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [7:0] LAT_LAST = 8'(MEM_LAT - 1);
    localparam logic [7:0] TMO_LAST = 8'(IO_TMO - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, IO_REQ, IO_WAIT, RESP} stateT;

    stateT       state;
    logic [5:0]  opR;
    logic [1:0]  offR;
    logic [4:0]  rdR;
    logic        storeR;
    logic [7:0]  cnt;
    logic        isByte, isHalf, isWord, isLoad, isStore, misaligned, isIo;
    logic [3:0]  weNext;
    logic [31:0] dinNext, loadData;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic        unusedAddr;

    assign req_ready  = state == IDLE;
    assign stall      = ~req_ready;
    assign unusedAddr = ^req_addr[27:ADDR_W+2];

    // Classify the incoming opcode and pre-align store lanes/data
    always_comb begin
        isByte     = req_op == OP_LB || req_op == OP_LBU || req_op == OP_SB;
        isHalf     = req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH;
        isWord     = req_op == OP_LW || req_op == OP_SW;
        isLoad     = req_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        isStore    = req_op inside {OP_SB, OP_SH, OP_SW};
        misaligned = (isHalf && req_addr[0]) || (isWord && |req_addr[1:0]);
        isIo       = req_addr[31:28] == IO_REGION;
        weNext     = isByte ? 4'b1000 >> req_addr[1:0] : isHalf ? (req_addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        dinNext    = isByte ? {4{req_wdata[7:0]}} : isHalf ? {2{req_wdata[15:0]}} : req_wdata;
    end

    // Pick the addressed big-endian lane from RAM data and extend it
    always_comb begin
        byteSel  = offR[1] ? (offR[0] ? mem_dout[7:0] : mem_dout[15:8]) : (offR[0] ? mem_dout[23:16] : mem_dout[31:24]);
        halfSel  = offR[1] ? mem_dout[15:0] : mem_dout[31:16];
        loadData = opR == OP_LB  ? {{24{byteSel[7]}}, byteSel} :
                   opR == OP_LBU ? {24'b0, byteSel} :
                   opR == OP_LH  ? {{16{halfSel[15]}}, halfSel} :
                   opR == OP_LHU ? {16'b0, halfSel} : mem_dout;
    end

    // Transaction FSM; all outputs registered, pulses default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            opR        <= '0;
            offR       <= '0;
            rdR        <= '0;
            storeR     <= 1'b0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_rd    <= '0;
            err        <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            io_valid   <= 1'b0;
            io_we      <= 1'b0;
            io_addr    <= '0;
            io_wdata   <= '0;
        end else begin
            mem_en     <= 1'b0;
            mem_we     <= '0;
            err        <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid && (isLoad || isStore)) begin
                    opR    <= req_op;
                    offR   <= req_addr[1:0];
                    rdR    <= req_rd;
                    storeR <= isStore;
                    if (misaligned || (isIo && !isWord)) begin
                        err <= 1'b1;
                    end else if (isIo) begin
                        state    <= IO_REQ;
                        io_valid <= 1'b1;
                        io_we    <= isStore;
                        io_addr  <= req_addr[7:0];
                        io_wdata <= req_wdata;
                        cnt      <= '0;
                    end else begin
                        state    <= ISSUE;
                        mem_en   <= 1'b1;
                        mem_we   <= isStore ? weNext : 4'b0;
                        mem_addr <= req_addr[ADDR_W+1:2];
                        mem_din  <= dinNext;
                    end
                end
                ISSUE: begin
                    state <= storeR ? IDLE : WAIT;
                    cnt   <= LAT_LAST;
                end
                WAIT: if (cnt == '0) begin
                    resp_valid <= 1'b1;
                    resp_rdata <= loadData;
                    resp_rd    <= rdR;
                    state      <= RESP;
                end else begin
                    cnt <= cnt - 8'd1;
                end
                IO_REQ: if (io_ready) begin
                    io_valid <= 1'b0;
                    cnt      <= '0;
                    state    <= io_we ? IDLE : IO_WAIT;
                end else if (cnt == TMO_LAST) begin
                    io_valid <= 1'b0;
                    err      <= 1'b1;
                    if (!io_we) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_rd    <= rdR;
                    end
                    state <= io_we ? IDLE : RESP;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                IO_WAIT: if (io_rvalid) begin
                    resp_valid <= 1'b1;
                    resp_rdata <= io_rdata;
                    resp_rd    <= rdR;
                    state      <= RESP;
                end else if (cnt == TMO_LAST) begin
                    err        <= 1'b1;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_rd    <= rdR;
                    state      <= RESP;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized check of two LSUs (MEM_LAT 1 and 4) against a byte-level memory model
module tb_mem_stage_lsu;
    localparam int TMO = 255;

    logic        clk, rst_n;
    logic        reqValid;
    logic [5:0]  reqOp;
    logic [31:0] reqAddr, reqWdata;
    logic [4:0]  reqRd;
    logic        ioReady, ioRvalid;
    logic [31:0] ioRdata;

    logic        reqReady [2];
    logic        respValid [2];
    logic [31:0] respRdata [2];
    logic [4:0]  respRd [2];
    logic        err [2];
    logic        stall [2];
    logic        memEn [2];
    logic [3:0]  memWe [2];
    logic [11:0] memAddr [2];
    logic [31:0] memDin [2];
    logic [31:0] memDout [2];
    logic        ioValid [2];
    logic        ioWe [2];
    logic [7:0]  ioAddr [2];
    logic [31:0] ioWdata [2];

    logic [7:0]  refMem [64];
    logic [31:0] ram [2][16];
    logic [31:0] pipe [2][4];
    logic        loadRam;
    int          tests = 0;
    int          fails = 0;
    string       ctx = "init";

    for (genvar g = 0; g < 2; g++) begin : gDut
        mem_stage_lsu #(.ADDR_W(12), .MEM_LAT(g == 0 ? 1 : 4), .IO_REGION(4'h8), .IO_TMO(TMO)) dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(reqValid), .req_ready(reqReady[g]), .req_op(reqOp), .req_addr(reqAddr),
            .req_wdata(reqWdata), .req_rd(reqRd),
            .resp_valid(respValid[g]), .resp_rdata(respRdata[g]), .resp_rd(respRd[g]),
            .err(err[g]), .stall(stall[g]),
            .mem_en(memEn[g]), .mem_we(memWe[g]), .mem_addr(memAddr[g]), .mem_din(memDin[g]),
            .mem_dout(memDout[g]),
            .io_valid(ioValid[g]), .io_ready(ioReady), .io_we(ioWe[g]), .io_addr(ioAddr[g]),
            .io_wdata(ioWdata[g]), .io_rvalid(ioRvalid), .io_rdata(ioRdata)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Block RAM environment: byte-lane writes, read data delayed by each DUT's latency, junk when not enabled
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (loadRam) begin
                for (int w = 0; w < 16; w++) ram[d][w] <= {refMem[4*w], refMem[4*w+1], refMem[4*w+2], refMem[4*w+3]};
            end else if (memEn[d]) begin
                for (int b = 0; b < 4; b++) if (memWe[d][b]) ram[d][memAddr[d][3:0]][8*b +: 8] <= memDin[d][8*b +: 8];
            end
            pipe[d][0] <= memEn[d] ? ram[d][memAddr[d][3:0]] : $urandom;
            for (int s = 1; s < 4; s++) pipe[d][s] <= pipe[d][s-1];
        end
    end
    assign memDout[0] = pipe[0][0];
    assign memDout[1] = pipe[1][3];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s %s: got %h expected %h", ctx, tag, got, exp);
        end
    endtask

    // One request: drive it, watch both DUTs cycle by cycle, then compare against the memory model
    task automatic runTxn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input int readyAt, input int rvalidAt, input logic [31:0] ioData);
        bit isLs = 1, isLoad = 0, sgn = 0, io, legal;
        int size = 1, off, maxK, lat;
        int ioErr = 0, ioResp = 0, ioReadyK = 1, ioCnt = 0;
        int eErr, eMem, eResp, eReady, eIo;
        logic [31:0] weExp, dinExp, dataExp;
        int memEnCnt [2], memEnAt [2], respCnt [2], respAt [2], errCnt [2], errAt [2];
        int firstReady [2], ioValidCnt [2], ioFirst [2], stallBad [2], weLeak [2], ioBad [2];
        logic [31:0] weSeen [2], addrSeen [2], dinSeen [2], respSeen [2], rdSeen [2];
        int i;
        case (op)
            6'h20: begin isLoad = 1; sgn = 1; size = 1; end
            6'h21: begin isLoad = 1; sgn = 1; size = 2; end
            6'h23: begin isLoad = 1; size = 4; end
            6'h24: begin isLoad = 1; size = 1; end
            6'h25: begin isLoad = 1; size = 2; end
            6'h28: size = 1;
            6'h29: size = 2;
            6'h2B: size = 4;
            default: isLs = 0;
        endcase
        off   = int'(addr[1:0]);
        io    = addr[31:28] == 4'h8;
        legal = isLs && (off % size == 0) && (!io || size == 4);
        weExp = 0;
        dinExp = 0;
        for (int b = 0; b < 4; b++) begin
            weExp[3-b] = b >= off && b < off + size;
            dinExp[8*(3-b) +: 8] = wdata[8*(size-1-(b % size)) +: 8];
        end
        dataExp = 0;
        for (int j = 0; j < size; j++) dataExp = (dataExp << 8) | 32'(refMem[(int'(addr[5:0]) + j) % 64]);
        if (sgn && dataExp[8*size-1]) dataExp = dataExp | ~((32'h1 << (8*size)) - 1);
        if (readyAt == 0) begin
            ioCnt = TMO; ioErr = TMO + 1; ioResp = isLoad ? TMO + 1 : 0; ioReadyK = isLoad ? TMO + 2 : TMO + 1;
        end else begin
            ioCnt = readyAt;
            if (!isLoad) ioReadyK = readyAt + 1;
            else if (rvalidAt == 0) begin ioErr = readyAt + TMO + 1; ioResp = ioErr; ioReadyK = ioErr + 1; end
            else begin ioResp = rvalidAt + 1; ioReadyK = rvalidAt + 2; end
        end
        if (isLoad && io) dataExp = (readyAt != 0 && rvalidAt != 0) ? ioData : 32'h0;
        maxK = (legal && io) ? ioReadyK + 3 : 12;
        ctx = $sformatf("op%h a%h", op, addr);
        for (i = 0; i < 600 && !(reqReady[0] && reqReady[1]); i++) @(negedge clk);
        if (i == 600) checkVal("idle_wait", 0, 1);
        for (int d = 0; d < 2; d++) begin
            memEnCnt[d] = 0; memEnAt[d] = 0; respCnt[d] = 0; respAt[d] = 0; errCnt[d] = 0; errAt[d] = 0;
            firstReady[d] = 0; ioValidCnt[d] = 0; ioFirst[d] = 0; stallBad[d] = 0; weLeak[d] = 0; ioBad[d] = 0;
            weSeen[d] = 0; addrSeen[d] = 0; dinSeen[d] = 0; respSeen[d] = 0; rdSeen[d] = 0;
        end
        reqValid = 1; reqOp = op; reqAddr = addr; reqWdata = wdata; reqRd = rd;
        for (int k = 1; k <= maxK; k++) begin
            @(negedge clk);
            reqValid = 0;
            for (int d = 0; d < 2; d++) begin
                if (memEn[d]) begin
                    memEnCnt[d]++;
                    if (memEnAt[d] == 0) memEnAt[d] = k;
                    weSeen[d] = 32'(memWe[d]); addrSeen[d] = 32'(memAddr[d]); dinSeen[d] = memDin[d];
                end else if (memWe[d] != 0) weLeak[d]++;
                if (respValid[d]) begin
                    respCnt[d]++;
                    if (respAt[d] == 0) respAt[d] = k;
                    respSeen[d] = respRdata[d]; rdSeen[d] = 32'(respRd[d]);
                end
                if (err[d]) begin errCnt[d]++; if (errAt[d] == 0) errAt[d] = k; end
                if (reqReady[d] && firstReady[d] == 0) firstReady[d] = k;
                if (ioValid[d]) begin
                    ioValidCnt[d]++;
                    if (ioFirst[d] == 0) ioFirst[d] = k;
                    if (ioWe[d] != !isLoad || ioAddr[d] != addr[7:0] || (!isLoad && ioWdata[d] != wdata)) ioBad[d]++;
                end
                if (stall[d] == reqReady[d]) stallBad[d]++;
            end
            ioReady  = k == readyAt;
            ioRvalid = k == readyAt || k == rvalidAt;
            ioRdata  = k == rvalidAt ? ioData : 32'hBAD0BAD0;
        end
        ioReady = 0; ioRvalid = 0; ioRdata = 0;
        for (int d = 0; d < 2; d++) begin
            lat = d == 0 ? 1 : 4;
            eErr = 0; eMem = 0; eResp = 0; eReady = 1; eIo = 0;
            if (isLs && !legal) eErr = 1;
            else if (isLs && !io) begin eMem = 1; eResp = isLoad ? 2 + lat : 0; eReady = isLoad ? 3 + lat : 2; end
            else if (isLs) begin eErr = ioErr; eResp = ioResp; eReady = ioReadyK; eIo = ioCnt; end
            ctx = $sformatf("d%0d op%h a%h", d, op, addr);
            checkVal("err_count", errCnt[d], eErr != 0 ? 1 : 0);
            checkVal("err_cycle", errAt[d], eErr);
            checkVal("memen_count", memEnCnt[d], eMem);
            checkVal("resp_count", respCnt[d], eResp != 0 ? 1 : 0);
            checkVal("resp_cycle", respAt[d], eResp);
            checkVal("ready_cycle", firstReady[d], eReady);
            checkVal("io_valid_cycles", ioValidCnt[d], eIo);
            checkVal("io_valid_start", ioFirst[d], eIo != 0 ? 1 : 0);
            checkVal("io_fields_bad", ioBad[d], 0);
            checkVal("stall_vs_ready", stallBad[d], 0);
            checkVal("we_without_en", weLeak[d], 0);
            if (eMem != 0) begin
                checkVal("memen_cycle", memEnAt[d], 1);
                checkVal("mem_we", weSeen[d], isLoad ? 0 : weExp);
                checkVal("mem_addr", addrSeen[d], 32'(addr[13:2]));
                if (!isLoad) checkVal("mem_din", dinSeen[d], dinExp);
            end
            if (eResp != 0) begin
                checkVal("resp_rdata", respSeen[d], dataExp);
                checkVal("resp_rd", rdSeen[d], 32'(rd));
                checkVal("rdata_hold", respRdata[d], dataExp);
            end
        end
        if (legal && !io && !isLoad)
            for (int b = off; b < off + size; b++) refMem[int'(addr[5:2])*4 + b] = dinExp[8*(3-b) +: 8];
    endtask

    initial begin
        logic [5:0] ops [10];
        logic [5:0] op;
        logic [31:0] addr;
        int ra, rv, cntBad;
        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h2A};
        rst_n = 0; reqValid = 0; reqOp = 0; reqAddr = 0; reqWdata = 0; reqRd = 0;
        ioReady = 0; ioRvalid = 0; ioRdata = 0; loadRam = 1;
        for (int b = 0; b < 64; b++) refMem[b] = 8'($urandom);
        repeat (3) @(negedge clk);
        loadRam = 0;
        ctx = "reset";
        for (int d = 0; d < 2; d++) begin
            checkVal("rst_req_ready", 32'(reqReady[d]), 1);
            checkVal("rst_stall", 32'(stall[d]), 0);
            checkVal("rst_outputs", {respValid[d], err[d], memEn[d], ioValid[d], ioWe[d], memWe[d]}, 0);
            checkVal("rst_rdata", respRdata[d], 0);
        end
        rst_n = 1;
        @(negedge clk);
        runTxn(6'h2B, 32'h10, 32'hDEADBEEF, 5'd1, 0, 0, 0);
        runTxn(6'h20, 32'h11, 0, 5'd7, 0, 0, 0);
        ctx = "lb_0x11";
        checkVal("lb_value", respRdata[0], 32'hFFFFFFAD);
        runTxn(6'h24, 32'h11, 0, 5'd8, 0, 0, 0);
        ctx = "lbu_0x11";
        checkVal("lbu_value", respRdata[1], 32'h000000AD);
        runTxn(6'h28, 32'h13, 32'h55, 5'd0, 0, 0, 0);
        runTxn(6'h29, 32'h12, 32'h1234, 5'd0, 0, 0, 0);
        runTxn(6'h23, 32'h10, 0, 5'd9, 0, 0, 0);
        runTxn(6'h23, 32'h6, 0, 5'd2, 0, 0, 0);
        runTxn(6'h21, 32'h3, 0, 5'd2, 0, 0, 0);
        runTxn(6'h20, 32'h80000000, 0, 5'd2, 0, 0, 0);
        runTxn(6'h23, 32'h80000004, 0, 5'd12, 4, 6, 32'h41);
        runTxn(6'h2B, 32'h80000010, 32'hCAFEF00D, 5'd0, 0, 0, 0);
        runTxn(6'h23, 32'h80000020, 0, 5'd13, 2, 0, 0);
        runTxn(6'h2B, 32'h800000F0, 32'h12345678, 5'd0, 1, 0, 0);
        // Reset while both units wait on RAM read data
        ctx = "reset_mid_load";
        reqValid = 1; reqOp = 6'h23; reqAddr = 32'h20; reqRd = 5'd3;
        @(negedge clk);
        reqValid = 0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) checkVal("busy_before_reset", 32'(stall[d]), 1);
        rst_n = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkVal("mid_rst_ready", 32'(reqReady[d]), 1);
            checkVal("mid_rst_outputs", {respValid[d], err[d], memEn[d], ioValid[d], stall[d]}, 0);
            checkVal("mid_rst_rdata", respRdata[d], 0);
        end
        @(negedge clk);
        rst_n = 1;
        for (int d = 0; d < 2; d++) begin
            cntBad = 0;
            for (int k = 0; k < 10; k++) begin
                if (k > 0) @(negedge clk);
                if (respValid[d] || err[d] || memEn[d] || ioValid[d]) cntBad++;
            end
            checkVal("post_rst_quiet", cntBad, 0);
        end
        for (int n = 0; n < 170; n++) begin
            op = ops[$urandom_range(0, 9)];
            addr = ($urandom_range(0, 7) << 28) | $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) addr = 32'h80000000 | $urandom_range(0, 255);
            ra = $urandom_range(1, 5);
            rv = ra + $urandom_range(1, 4);
            runTxn(op, addr, $urandom, 5'($urandom_range(0, 31)), ra, rv, $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
